clk_phase_monitor: RTL

CLK_PHASE_MONITOR -- requirements
Module: clk_phase_monitor

---
 rtl/clk_phase_monitor.sv | 131 +++++++++++++
 1 files changed

// File: rtl/clk_phase_monitor.sv
// Checks the 8-phase sequence produced by the clock generator. It locks once
// LOCK_PERIODS clean periods have been seen, then reports the phase index and any sequence errors.
module clk_phase_monitor #(
  parameter int LOCK_PERIODS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk2_i,
  input  logic       clk4_i,
  input  logic       fetch_i,
  input  logic       alu_clk_i,
  output logic [2:0] phase,
  output logic       locked,
  output logic       period_start,
  output logic       err,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

  localparam logic [3:0] P0_CODE = 4'b1001;

  state_t     state_q, state_d;
  logic [2:0] exp_q, exp_d;
  logic [3:0] good_q, good_d;
  logic [2:0] phase_q, phase_d;
  logic       locked_q, locked_d;
  logic       period_start_q, period_start_d;
  logic       err_q, err_d;
  logic [7:0] err_count_q, err_count_d;

  logic [3:0] v;
  logic       match;
  logic       anchor;

  function automatic logic [3:0] phase_code(input logic [2:0] idx);
    case (idx)
      3'd0:    phase_code = 4'b1001;
      3'd1:    phase_code = 4'b0100;
      3'd2:    phase_code = 4'b1100;
      3'd3:    phase_code = 4'b0010;
      3'd4:    phase_code = 4'b1010;
      3'd5:    phase_code = 4'b0110;
      3'd6:    phase_code = 4'b1110;
      default: phase_code = 4'b0000;
    endcase
  endfunction

  // The phase clocks are launched on negedge, so they are already stable at posedge.
  assign v      = {clk2_i, clk4_i, fetch_i, alu_clk_i};
  assign match  = (v == phase_code(exp_q));
  assign anchor = (v == P0_CODE);

  always_comb begin
    state_d        = state_q;
    exp_d          = exp_q;
    good_d         = good_q;
    phase_d        = phase_q;
    period_start_d = 1'b0;
    err_d          = 1'b0;
    err_count_d    = err_count_q;
    case (state_q)
      HUNT: begin
        if (anchor) begin
          state_d = TRACK;
          exp_d   = 3'd1;
          good_d  = 4'd0;
        end
      end
      TRACK, LOCKED: begin
        if (match) begin
          exp_d = exp_q + 3'd1;
          if (state_q == LOCKED) begin
            phase_d        = exp_q;
            period_start_d = (exp_q == 3'd0);
          end else if (exp_q == 3'd7) begin
            good_d = good_q + 4'd1;
            // Lock on the closing P7 itself, so phase already reads 7 at lock.
            if (good_q + 4'd1 == 4'(LOCK_PERIODS)) begin
              state_d = LOCKED;
              phase_d = exp_q;
            end
          end
        end else begin
          if (state_q == LOCKED) begin
            err_d = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          end
          if (anchor) begin
            state_d = TRACK;
            exp_d   = 3'd1;
            good_d  = 4'd0;
          end else begin
            state_d = HUNT;
          end
        end
      end
      default: state_d = HUNT;
    endcase
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= HUNT;
      exp_q          <= 3'd0;
      good_q         <= 4'd0;
      phase_q        <= 3'd0;
      locked_q       <= 1'b0;
      period_start_q <= 1'b0;
      err_q          <= 1'b0;
      err_count_q    <= 8'd0;
    end else begin
      state_q        <= state_d;
      exp_q          <= exp_d;
      good_q         <= good_d;
      phase_q        <= phase_d;
      locked_q       <= locked_d;
      period_start_q <= period_start_d;
      err_q          <= err_d;
      err_count_q    <= err_count_d;
    end
  end

  assign phase        = phase_q;
  assign locked       = locked_q;
  assign period_start = period_start_q;
  assign err          = err_q;
  assign err_count    = err_count_q;

endmodule
